// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer with run/step/halt and retired-instruction counter; MULTICYCLE_CTRL_ILLEGAL_TRAP_EN traps undefined opcodes
module multicycle_ctrl #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  input  logic [5:0]         opcode,
  input  logic [3:0]         funct,
  input  logic               alu_zero,
  output logic               pc_store,
  output logic               reg_block_w,
  output logic               dmem_w,
  output logic [3:0]         alu_funct,
  output logic               m1_num,
  output logic               m2_num,
  output logic               m3_num,
  output logic               m4_num,
  output logic               m5_num,
  output logic               m6_num,
  output logic               m7_num,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic               instr_done,
  output logic [COUNT_W-1:0] instr_count
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;
  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd1;
  localparam logic [5:0] OP_LW   = 6'd2;
  localparam logic [5:0] OP_SW   = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_J    = 6'd6;
  localparam logic [5:0] OP_HALT = 6'd63;
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  logic [2:0]         state_q, state_d;
  logic [9:0]         ir_q, ir_d;
  logic               os_q, os_d;
  logic               done_q;
  logic [COUNT_W-1:0] cnt_q;
  logic [5:0]         op;
  logic [3:0]         fn;
  logic               known, trap, active, fin;
  assign op     = ir_q[9:4];
  assign fn     = ir_q[3:0];
  assign known  = (op <= OP_J) || (op == OP_HALT);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign trap   = !known;
`else
  assign trap   = 1'b0;
`endif
  assign active = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
  // fin marks the last cycle of an instruction: it carries pc_store and triggers retirement
  assign fin = ((state_q == S_EXEC) && (op == OP_BEQ || op == OP_BNE || op == OP_J || (!known && !trap)))
            || ((state_q == S_MEM) && (op == OP_SW))
            || (state_q == S_WB);
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    os_d    = os_q;
    case (state_q)
      S_IDLE: begin
        state_d = (run || step) ? S_FETCH : S_IDLE;
        os_d    = !run && step;
      end
      S_FETCH: begin
        ir_d    = {opcode, funct};
        state_d = S_EXEC;
      end
      S_EXEC:  state_d = (op == OP_R || op == OP_ADDI) ? S_WB :
                         (op == OP_LW || op == OP_SW) ? S_MEM :
                         (op == OP_HALT || trap) ? S_HALT : S_IDLE;
      S_MEM:   state_d = S_WB;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      state_d = (run && !os_q) ? S_FETCH : S_IDLE;
      os_d    = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      os_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      os_q    <= os_d;
      done_q  <= fin;
      cnt_q   <= cnt_q + COUNT_W'(fin);
    end
  end
  assign pc_store    = fin;
  assign reg_block_w = state_q == S_WB;
  assign dmem_w      = (state_q == S_MEM) && (op == OP_SW);
  assign alu_funct   = !active ? 4'h0 : (op == OP_R) ? fn :
                       (op == OP_BEQ || op == OP_BNE) ? ALU_SUB : ALU_ADD;
  assign m1_num      = active && ((op == OP_BEQ && alu_zero) || (op == OP_BNE && !alu_zero));
  assign m2_num      = active && (op == OP_J);
  assign m3_num      = active && (op == OP_R || op == OP_ADDI || op == OP_LW);
  assign m4_num      = active && (op == OP_R);
  assign m5_num      = active && (op == OP_SW);
  assign m6_num      = active && (op == OP_ADDI || op == OP_LW || op == OP_SW);
  assign m7_num      = active && (op == OP_LW);
  assign busy        = (state_q == S_FETCH) || active;
  assign halted      = state_q == S_HALT;
  assign illegal     = halted && trap;
  assign instr_done  = done_q;
  assign instr_count = cnt_q;
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the 16-bit single-issue datapath. It decodes `opcode`/`funct`/`alu_zero` and drives every datapath strobe and mux select over 2–4 cycles per instruction. Write strobes (`pc_store`, `reg_block_w`, `dmem_w`) are held to exactly one cycle, in the final state of each instruction. It sits beside `dataflow` in the top level and adds run/step/halt control and a retired-instruction counter for bring-up.

## Interface
- `COUNT_W`, default 16: width of `instr_count`.
- `clk`, in, 1: clock, all state updates on rising edge.
- `rst`, in, 1: asynchronous reset, active-high.
- `run`, in, 1: level. While high, the block fetches back-to-back instructions.
- `step`, in, 1: single-cycle pulse. Sampled only in IDLE; executes one instruction.
- `opcode`, in, 6: instruction bits [15:10].
- `funct`, in, 4: instruction bits [3:0].
- `alu_zero`, in, 1: ALU result equals zero.
- `pc_store`, `reg_block_w`, `dmem_w`, out, 1 each: write strobes.
- `alu_funct`, out, 4: ALU op. Fixed encodings: ADD=4'h0, SUB=4'h1.
- `m1_num`..`m7_num`, out, 1 each: datapath selects.
  - m1: 1 selects PC+1+const.
  - m2: 1 selects jump target.
  - m3: 1 selects rn_1=s1, 0 selects t.
  - m4: 1 selects rn_2=s2, 0 selects s1.
  - m5: 1 selects ALU in1=rd2.
  - m6: 1 selects ALU in2=const.
  - m7: 1 selects write data from dmem.
- `busy`, out, 1: instruction in flight.
- `halted`, out, 1: HALT executed.
- `illegal`, out, 1: illegal opcode trapped (macro only).
- `instr_done`, out, 1: one-cycle pulse per retired instruction.
- `instr_count`, out, `COUNT_W`: retired instructions, wraps modulo 2^COUNT_W.

## Operation
- **States:** IDLE, FETCH, EXEC, MEM, WB, HALT.
- **IDLE**
  - `run`=1 → FETCH.
  - `step`=1 → FETCH, with a one-shot flag set.
  - Otherwise stay in IDLE.
- **FETCH:** capture `opcode`/`funct` into an internal IR, then go to EXEC. All selects decode from the IR, never from the live inputs.
- **Opcodes and selects** (unlisted selects = 0)
  - 0 R-type: m3=1, m4=1, `alu_funct`=funct. Path EXEC→WB; WB asserts `reg_block_w` and `pc_store`.
  - 1 ADDI: m3=1, m6=1, ADD. Same path as R-type.
  - 2 LW: m3=1, m6=1, m7=1, ADD. Path EXEC→MEM→WB; WB asserts `reg_block_w` and `pc_store`.
  - 3 SW: m5=1, m6=1, ADD. Path EXEC→MEM; MEM asserts `dmem_w` and `pc_store`.
  - 4 BEQ / 5 BNE: SUB on t,s1.
    - EXEC asserts `pc_store`.
    - m1 = `alu_zero` for BEQ, `!alu_zero` for BNE.
    - m1 is the only output with a combinational dependence on an input.
  - 6 J: m2=1. EXEC asserts `pc_store`.
  - 63 HALT: EXEC → HALT state. No `pc_store`. `halted`=1. Exits only on `rst`.
  - Others: see Configuration.
- **After the final state**
  - `instr_done` pulses and `instr_count` increments in the cycle following the final state.
  - Next state is FETCH if `run`=1 and the one-shot flag is clear; otherwise IDLE, with the one-shot flag cleared.
- **Busy and selects:** `busy`=1 in FETCH, EXEC, MEM and WB. Selects stay stable from EXEC through the final state.

## Timing
- **Latency in cycles, counted from FETCH:** R/ADDI 3, LW 4, SW 3, BEQ/BNE/J 2.
- **Reset values:** every output 0, including `instr_count`; state is IDLE.
- **Reset mid-instruction:** strobes drop asynchronously. No partial write is allowed on the following edge.
- **Simultaneous `run` and `step` in IDLE:** `run` wins and the one-shot flag is not set.
- **`step` outside IDLE:** ignored, not queued.
- **`run` deasserted mid-instruction:** the instruction completes, then the block returns to IDLE.
- **Counter wrap:** `instr_count` wraps from 0xFFFF to 0x0000 without a flag.

## Configuration
- **`MULTICYCLE_CTRL_ILLEGAL_TRAP_EN` defined:**
  - An undefined opcode in EXEC → HALT with `illegal`=1 and `halted`=1.
  - No strobes fire and the instruction is not counted.
- **Macro undefined:**
  - An undefined opcode executes as a NOP: EXEC asserts `pc_store` with m1=m2=0, and the instruction is counted.
  - `illegal` is tied to 0.

## Test plan
- **ADDI:** reset, `run`=1, ADDI t=1 s1=0 const=5 → `reg_block_w` high only in cycle 3 (WB), m6=1, `alu_funct`=0, `instr_count`=1.
- **BEQ:** BEQ with `alu_zero`=1, then BNE with `alu_zero`=1 → BEQ: m1=1 with `pc_store`; BNE: m1=0 with `pc_store`. Each takes 2 cycles.
- **SW then LW:** SW → `dmem_w` for exactly 1 cycle with m5=m6=1 and no `reg_block_w`; then LW → m7=1 and `reg_block_w` in cycle 4.
- **Step:** `run`=0, `step` pulse → one R-type retires, `instr_done`=1 once, back in IDLE. A second `step` issued while `busy` is ignored.
- **HALT and reset:** HALT opcode → `halted`=1 and no further `pc_store` for 20 cycles. Then assert `rst` mid-LW of a new program → all outputs 0 immediately.
- **Illegal opcode:** opcode 0x20 → with the macro: `illegal`=1, `halted`=1, `instr_count` unchanged. Without the macro: NOP, `instr_count`+1.
